// File: rtl/instr_scan_block.sv
// Pre-decode stage: splits a fetch block into per-parcel instruction slots, carries a
// 32-bit instruction that straddles two blocks, and classifies control flow.
module instr_scan_block #(
   parameter int FETCH_WIDTH = 64,
   localparam int NPARCEL = FETCH_WIDTH / 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [FETCH_WIDTH-1:0]      data_i,
   input  logic [63:0]                 addr_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [NPARCEL-1:0]          instr_valid_o,
   output logic [NPARCEL-1:0][31:0]    instr_o,
   output logic [NPARCEL-1:0][63:0]    instr_addr_o,
   output logic [NPARCEL-1:0]          is_rvc_o,
   output logic [NPARCEL-1:0][2:0]     cf_type_o,
   output logic [NPARCEL-1:0][63:0]    imm_o
);

   localparam int OFFW = $clog2(FETCH_WIDTH / 8);

   localparam logic [2:0] CF_NONE   = 3'd0;
   localparam logic [2:0] CF_BRANCH = 3'd1;
   localparam logic [2:0] CF_JUMP   = 3'd2;
   localparam logic [2:0] CF_JALR   = 3'd3;
   localparam logic [2:0] CF_RETURN = 3'd4;
   localparam logic [2:0] CF_CALL   = 3'd5;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // Returns {cf_type, sign-extended immediate}.
   function automatic logic [66:0] cf_decode(input logic [31:0] i, input logic rvc);
      logic        [2:0]  cf;
      logic signed [63:0] imm;
      cf  = CF_NONE;
      imm = '0;
      if (rvc) begin
         if (i[1:0] == 2'b01 && i[15:13] == 3'b101) begin
            cf  = CF_JUMP;
            imm = {{52{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
         end else if (i[1:0] == 2'b01 && i[15:14] == 2'b11) begin
            cf  = CF_BRANCH;
            imm = {{55{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
         end else if (i[1:0] == 2'b10 && i[15:13] == 3'b100 && i[6:2] == 5'd0 && i[11:7] != 5'd0) begin
            if (i[12])
               cf = CF_CALL;
            else
               cf = is_link(i[11:7]) ? CF_RETURN : CF_JALR;
         end
      end else begin
         case (i[6:0])
            7'b1100011: begin
               cf  = CF_BRANCH;
               imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'b1101111: begin
               cf  = is_link(i[11:7]) ? CF_CALL : CF_JUMP;
               imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b1100111: begin
               if (is_link(i[11:7]))
                  cf = CF_CALL;
               else
                  cf = is_link(i[19:15]) ? CF_RETURN : CF_JALR;
            end
            default: cf = CF_NONE;
         endcase
      end
      return {cf, imm};
   endfunction

   logic                     pend_p1;
   logic [15:0]              held_p1;
   logic [63:0]              held_addr_p1;

   logic [NPARCEL:0][15:0]   pext;
   logic [63:0]              base;
   logic [NPARCEL-1:0]       iv_p0, rvc_p0;
   logic [NPARCEL-1:0][31:0] ins_p0;
   logic [NPARCEL-1:0][63:0] adr_p0, imm_p0;
   logic [NPARCEL-1:0][2:0]  cf_p0;
   logic                     pend_p0;
   logic [15:0]              held_p0;
   logic [63:0]              held_addr_p0;
   logic                     unused_addr_lsb;

   assign unused_addr_lsb = addr_i[0];
   assign pext    = {16'h0000, data_i};
   assign base    = {addr_i[63:OFFW], {OFFW{1'b0}}};
   assign ready_o = !valid_o || ready_i;

   // Stage p0: scan parcels and decode each occupied slot.
   always_comb begin
      int  start;
      logic skip;
      iv_p0        = '0;
      rvc_p0       = '0;
      ins_p0       = '0;
      adr_p0       = '0;
      cf_p0        = '0;
      imm_p0       = '0;
      pend_p0      = 1'b0;
      held_p0      = held_p1;
      held_addr_p0 = held_addr_p1;
      skip         = 1'b0;
      start        = pend_p1 ? 1 : int'(addr_i[OFFW-1:1]);
      if (pend_p1) begin
         iv_p0[0]  = 1'b1;
         ins_p0[0] = {pext[0], held_p1};
         adr_p0[0] = held_addr_p1;
      end
      for (int p = 0; p < NPARCEL; p++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (p >= start) begin
            if (pext[p][1:0] != 2'b11) begin
               iv_p0[p]  = 1'b1;
               rvc_p0[p] = 1'b1;
               ins_p0[p] = {16'h0000, pext[p]};
               adr_p0[p] = base + 64'(2 * p);
            end else if (p == NPARCEL - 1) begin
               pend_p0      = 1'b1;
               held_p0      = pext[p];
               held_addr_p0 = base + 64'(2 * p);
            end else begin
               iv_p0[p]  = 1'b1;
               ins_p0[p] = {pext[p+1], pext[p]};
               adr_p0[p] = base + 64'(2 * p);
               skip      = 1'b1;
            end
         end
      end
      for (int k = 0; k < NPARCEL; k++) begin
         if (iv_p0[k])
            {cf_p0[k], imm_p0[k]} = cf_decode(ins_p0[k], rvc_p0[k]);
      end
   end

   // Stage p1: registered output slots and straddle holding register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o       <= 1'b0;
         pend_p1       <= 1'b0;
         held_p1       <= '0;
         held_addr_p1  <= '0;
         instr_valid_o <= '0;
         instr_o       <= '0;
         instr_addr_o  <= '0;
         is_rvc_o      <= '0;
         cf_type_o     <= '0;
         imm_o         <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
         pend_p1 <= 1'b0;
      end else if (valid_i && ready_o) begin
         valid_o       <= 1'b1;
         pend_p1       <= pend_p0;
         held_p1       <= held_p0;
         held_addr_p1  <= held_addr_p0;
         instr_valid_o <= iv_p0;
         instr_o       <= ins_p0;
         instr_addr_o  <= adr_p0;
         is_rvc_o      <= rvc_p0;
         cf_type_o     <= cf_p0;
         imm_o         <= imm_p0;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_scan_block.sv
// Scoreboard bench for instr_scan_block (FETCH_WIDTH=64): directed blocks with
// hand-computed slot expectations queued at drive time and compared at output.
module tb_instr_scan_block;

   logic              clk = 1'b0;
   logic              rst_i, flush_i, valid_i, ready_i;
   logic              ready_o, valid_o;
   logic [63:0]       data_i, addr_i;
   logic [3:0]        instr_valid_o, is_rvc_o;
   logic [3:0][31:0]  instr_o;
   logic [3:0][63:0]  instr_addr_o, imm_o;
   logic [3:0][2:0]   cf_type_o;

   instr_scan_block #(.FETCH_WIDTH(64)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .addr_i(addr_i), .valid_o(valid_o), .ready_i(ready_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_addr_o(instr_addr_o),
      .is_rvc_o(is_rvc_o), .cf_type_o(cf_type_o), .imm_o(imm_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       iv, rvc;
      logic [3:0][31:0] ins;
      logic [3:0][63:0] adr, imm;
      logic [3:0][2:0]  cf;
   } exp_t;

   exp_t e;
   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_clr();
      e = '{default: '0};
   endtask

   task automatic exp_slot(input int k, input logic [31:0] ins, input logic [63:0] adr,
                           input logic rvc, input logic [2:0] cf, input logic [63:0] imm);
      e.iv[k]  = 1'b1;
      e.rvc[k] = rvc;
      e.ins[k] = ins;
      e.adr[k] = adr;
      e.cf[k]  = cf;
      e.imm[k] = imm;
   endtask

   task automatic exp_nops(input logic [63:0] base, input logic [3:0] mask);
      for (int k = 0; k < 4; k++)
         if (mask[k]) exp_slot(k, 32'h0000_0001, base + 64'(2 * k), 1'b1, 3'd0, 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] d, output int acc);
      logic rdy;
      valid_i = 1'b1;
      addr_i  = a;
      data_i  = d;
      acc     = 0;
      for (int n = 1; n <= 20 && acc == 0; n++) begin
         @(negedge clk);
         rdy = ready_o;
         @(posedge clk);
         #1;
         if (rdy) acc = n;
      end
      valid_i = 1'b0;
      if (acc == 0) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   // Scoreboard monitor: an output block is consumed when valid_o && ready_i.
   initial begin
      exp_t o;
      forever begin
         @(negedge clk);
         if (valid_o === 1'b1 && ready_i === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               o = q.pop_front();
               chk("instr_valid", 64'(instr_valid_o), 64'(o.iv));
               chk("is_rvc", 64'(is_rvc_o), 64'(o.rvc));
               for (int k = 0; k < 4; k++) begin
                  chk($sformatf("instr[%0d]", k), 64'(instr_o[k]), 64'(o.ins[k]));
                  chk($sformatf("addr[%0d]", k), instr_addr_o[k], o.adr[k]);
                  chk($sformatf("cf[%0d]", k), 64'(cf_type_o[k]), 64'(o.cf[k]));
                  chk($sformatf("imm[%0d]", k), imm_o[k], o.imm[k]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      data_i = '0; addr_i = '0;
      idle(2);
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_valid_o", 64'(valid_o), 64'd0);
      chk("rst_ready_o", 64'(ready_o), 64'd1);
      chk("rst_instr_valid", 64'(instr_valid_o), 64'd0);
      chk("rst_instr0", 64'(instr_o[0]), 64'd0);
      chk("rst_imm0", imm_o[0], 64'd0);
      chk("rst_cf", 64'(cf_type_o), 64'd0);
      @(posedge clk);
      #1;

      // Four C.NOPs.
      exp_clr(); exp_nops(64'h8000_0000, 4'hF); q.push_back(e);
      send(64'h8000_0000, 64'h0001_0001_0001_0001, cyc);

      // JAL x1,+0x100 then two C.NOPs.
      exp_clr(); exp_slot(0, 32'h1000_00EF, 64'h100, 1'b0, 3'd5, 64'h100);
      exp_nops(64'h100, 4'b1100); q.push_back(e);
      send(64'h100, 64'h0001_0001_1000_00EF, cyc);

      // BEQ -8 split across two blocks.
      exp_clr(); exp_nops(64'h1000, 4'b0111); q.push_back(e);
      send(64'h1000, 64'h0CE3_0001_0001_0001, cyc);
      exp_clr(); exp_slot(0, 32'hFE00_0CE3, 64'h1006, 1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8);
      exp_nops(64'h1008, 4'b1110); q.push_back(e);
      send(64'h1008, 64'h0001_0001_0001_FE00, cyc);

      // Offset start: C.JR x1 at parcel 2, ADDI NOP straddling into the next block.
      exp_clr(); exp_slot(2, 32'h0000_8082, 64'h2004, 1'b1, 3'd4, 64'd0); q.push_back(e);
      send(64'h2004, 64'h0013_8082_0001_0001, cyc);
      exp_clr(); exp_slot(0, 32'h0000_0013, 64'h2006, 1'b0, 3'd0, 64'd0);
      exp_nops(64'h2008, 4'b1110); q.push_back(e);
      send(64'h2008, 64'h0001_0001_0001_0000, cyc);
      idle(2);

      // Back-pressure: compressed control flow block held for three cycles.
      ready_i = 1'b0;
      exp_clr();
      exp_slot(0, 32'h0000_A801, 64'h3000, 1'b1, 3'd2, 64'h10);
      exp_slot(1, 32'h0000_DC7D, 64'h3002, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFE);
      exp_slot(2, 32'h0000_9082, 64'h3004, 1'b1, 3'd5, 64'd0);
      exp_slot(3, 32'h0000_8282, 64'h3006, 1'b1, 3'd4, 64'd0);
      q.push_back(e);
      send(64'h3000, 64'h8282_9082_DC7D_A801, cyc);
      exp_clr();
      exp_slot(0, 32'h0000_8067, 64'h3008, 1'b0, 3'd4, 64'd0);
      exp_slot(2, 32'hFFDF_F06F, 64'h300C, 1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC);
      q.push_back(e);
      fork
         send(64'h3008, 64'hFFDF_F06F_0000_8067, cyc);
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("stall_ready_o", 64'(ready_o), 64'd0);
               chk("stall_valid_o", 64'(valid_o), 64'd1);
               chk("stall_instr1", 64'(instr_o[1]), 64'h0000_DC7D);
               chk("stall_imm1", imm_o[1], 64'hFFFF_FFFF_FFFF_FFFE);
               chk("stall_cf3", 64'(cf_type_o[3]), 64'd4);
               @(posedge clk);
               #1;
            end
            ready_i = 1'b1;
         end
      join
      chk("stall_accept_cycle", 64'(cyc), 64'd4);

      // Pending straddle cancelled by flush (m=0) or reset (m=1).
      for (int m = 0; m < 2; m++) begin
         exp_clr(); exp_nops(64'h4000, 4'b0111); q.push_back(e);
         send(64'h4000, 64'h0CE3_0001_0001_0001, cyc);
         valid_i = 1'b1; addr_i = 64'h5000; data_i = 64'h0001_0001_0001_0001;
         if (m == 0) flush_i = 1'b1;
         else        rst_i   = 1'b1;
         @(posedge clk);
         #1;
         flush_i = 1'b0; rst_i = 1'b0; valid_i = 1'b0;
         @(negedge clk);
         chk(m == 0 ? "flush_valid_o" : "rst2_valid_o", 64'(valid_o), 64'd0);
         chk(m == 0 ? "flush_ready_o" : "rst2_ready_o", 64'(ready_o), 64'd1);
         if (m == 1) chk("rst2_instr_valid", 64'(instr_valid_o), 64'd0);
         @(posedge clk);
         #1;
         exp_clr(); exp_nops(64'h4008, 4'hF); q.push_back(e);
         send(64'h4008, 64'h0001_0001_0001_0001, cyc);
      end

      idle(3);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
